// File: rtl/alu_pkg.sv
// Opcode constants, ALU_control codes and the pure RV32I ALU-control decode.
// The illegal flag is carried in alu_dec_t only when ALU_DEC_ILLEGAL_EN is defined.
package alu_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00010,
        ALU_SLL  = 5'b00100,
        ALU_SLT  = 5'b01000,
        ALU_SLTU = 5'b01100,
        ALU_XOR  = 5'b10000,
        ALU_SRL  = 5'b10100,
        ALU_SRA  = 5'b10110,
        ALU_OR   = 5'b11000,
        ALU_AND  = 5'b11100,
        ALU_BGE  = 5'b11010,
        ALU_BGEU = 5'b11110,
        ALU_LUI  = 5'b11111
    } alu_op_t;

`ifdef ALU_DEC_ILLEGAL_EN
    typedef struct packed {
        logic    illegal;
        alu_op_t op;
    } alu_dec_t;
`else
    typedef struct packed {
        alu_op_t op;
    } alu_dec_t;
`endif

    // alt selects SUB for f3=000 and SRA for f3=101
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_dec_t decode_alu(input logic [31:0] instr);
        alu_dec_t   d;
        alu_op_t    op;
        logic       ill;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7b5;
        opc  = instr[6:0];
        f3   = instr[14:12];
        f7b5 = instr[30];
        op   = ALU_ADD;
        ill  = 1'b0;
        case (opc)
            OP_R: op = arith_op(f3, f7b5);
            OP_I: op = arith_op(f3, f7b5 & (f3 == 3'b101));
            OP_B: begin
                case (f3)
                    3'b000, 3'b001: op = ALU_SUB;
                    3'b100:         op = ALU_SLT;
                    3'b101:         op = ALU_BGE;
                    3'b110:         op = ALU_SLTU;
                    3'b111:         op = ALU_BGEU;
                    default:        ill = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC: op = ALU_ADD;
            OP_LUI: op = ALU_LUI;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            op = ALU_ADD;
        end
        d.op = op;
`ifdef ALU_DEC_ILLEGAL_EN
        d.illegal = ill;
`endif
        return d;
    endfunction

endpackage

// File: rtl/alu_dec_skid.sv
// Generic two-entry valid/ready buffer; out_data_o comes straight from the head register
// and in_ready_o depends only on occupancy, so neither port has a combinational through-path.
module alu_dec_skid #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);

    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign in_ready_o  = (count_q != 2'd2) & ~rst_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = in_data_i;
                        count_d = 2'd2;
                    end
                    2'b01:   count_d = 2'd0;
                    2'b11:   head_d  = in_data_i;
                    default: ;
                endcase
            end
            2'd2: begin
                // full: push is blocked, so only a pop can move the tail up
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// Pipelined RV32I ALU-control decoder: combinational decode into a two-entry output buffer.
// Define ALU_DEC_ILLEGAL_EN to add the illegal output and carry it through the buffer.
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_ready,
    output logic            out_valid,
    output logic [4:0]      ALU_control,
`ifdef ALU_DEC_ILLEGAL_EN
    output logic            illegal,
`endif
    input  logic            out_ready
);

    alu_dec_t dec_in;
    alu_dec_t dec_out;

    assign dec_in = decode_alu(in_instr);

    alu_dec_skid #(
        .W ($bits(alu_dec_t))
    ) u_skid (
        .clk_i       (CLK),
        .rst_i       (RSTa),
        .in_valid_i  (in_valid),
        .in_data_i   (dec_in),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (dec_out),
        .out_ready_i (out_ready)
    );

    assign ALU_control = dec_out.op;
`ifdef ALU_DEC_ILLEGAL_EN
    assign illegal     = dec_out.illegal;
`endif

endmodule

// File: doc/alu_ctrl_decoder.md
# alu_ctrl_decoder

Pipelined ALU-control decoder for the RV32I core. It accepts 32-bit instruction words over a valid/ready handshake and produces the 5-bit `ALU_control` code consumed by the ALU. Outputs are registered through a two-entry elastic buffer, so decode sits between fetch and the execute stage without a combinational ready path.

## Interface

- `XLEN`, default 32: instruction word width. Only 32 is supported.
- `CLK`, in, 1: single clock, rising edge.
- `RSTa`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `in_instr` is valid.
- `in_instr`, in, XLEN: instruction word.
- `in_ready`, out, 1: decoder can accept a word this cycle.
- `out_valid`, out, 1: `ALU_control` is valid.
- `ALU_control`, out, 5: decoded ALU operation.
- `out_ready`, in, 1: consumer accepts this cycle.
- `illegal`, out, 1: instruction not decodable. Present only with `ALU_DEC_ILLEGAL_EN`.

## Operation

- Fields: opcode = `instr[6:0]`, f3 = `instr[14:12]`, f7b5 = `instr[30]`.
- Opcode 0110011 (R-type), by f3:
  - 000: ADD 00000 if f7b5=0, SUB 00010 if f7b5=1.
  - 001 SLL 00100; 010 SLT 01000; 011 SLTU 01100; 100 XOR 10000.
  - 101: SRL 10100 if f7b5=0, SRA 10110 if f7b5=1.
  - 110 OR 11000; 111 AND 11100.
- Opcode 0010011 (I-type ALU): same mapping as R-type, except f3=000 is always ADD (f7b5 ignored).
- Opcode 1100011 (branch), by f3:
  - 000 and 001: SUB 00010.
  - 100: 01000; 101: 11010; 110: 01100; 111: 11110.
  - 010 and 011: illegal.
- Opcodes 0000011, 0100011, 1101111, 1100111, 0010111 (load, store, JAL, JALR, AUIPC): ADD 00000.
- Opcode 0110111 (LUI): 11111.
- Any other opcode: illegal. `ALU_control` is 00000 for illegal words.
- Buffer: two entries, FIFO order. An occupancy counter holds 0, 1 or 2.

## Timing

- Transfers happen on `valid & ready` at the rising edge of `CLK`, on both ports.
- Latency: a word accepted in cycle N appears with `out_valid=1` in cycle N+1 if the buffer was empty.
- Throughput: one word per cycle while `out_ready=1`.
- `in_ready` equals `(count != 2) & ~RSTa`. It is registered-state only, with no dependence on `out_ready`.
- Simultaneous push and pop: occupancy is unchanged and order is preserved. With count=2, no push is possible; a pop alone makes count 1.
- Output stability: `out_valid` and `ALU_control` hold while `out_valid & ~out_ready`.
- Reset values: count=0, `out_valid=0`, `ALU_control=00000`, `illegal=0`, `in_ready=0` while `RSTa` is high.
- Reset mid-operation: buffered words are discarded immediately on assertion (asynchronous). The first accept is possible in the first cycle after deassertion.

## Configuration

- Macro: `ALU_DEC_ILLEGAL_EN`.
- When defined:
  - The `illegal` port exists and travels with each entry through the buffer.
  - It is high exactly for words classed illegal above.
- When undefined:
  - The port and its storage are absent.
  - Illegal words still decode to 00000 and pass normally.

## Structure

- Package `alu_pkg` holds:
  - the opcode constants;
  - a `typedef enum logic [4:0] alu_op_t` carrying the 13 ALU_control codes listed above;
  - a pure function `decode_alu(instr)` returning the code (plus the illegal bit under the macro).
- Sub-module `alu_dec_skid` is the generic two-entry valid/ready buffer, parameterised on payload width. The top level instantiates it with payload = ALU_control (+ illegal).

## Test plan

- Single words with `out_ready=1`, each appearing one cycle after accept:
  - 0x003100B3 (add) -> 00000.
  - 0x403100B3 (sub) -> 00010.
  - 0x403150B3 (sra) -> 10110.
- Branch and upper-immediate decode:
  - 0x0020D063 (bge) -> 11010.
  - 0x123450B7 (lui) -> 11111.
  - 0x00310093 (addi, f7b5 = 0) -> 00000.
- Backpressure:
  - Hold `out_ready=0` and push add, sub, sra on consecutive cycles.
  - Only add and sub are accepted, and `in_ready` is 0 after the second accept.
  - Release `out_ready`: codes 00000 then 00010 appear in order, then sra is accepted.
- Illegal word 0x00000000 with the macro defined -> `ALU_control`=00000, `illegal`=1. Without the macro -> 00000 only.
- Streaming: 100 random legal words with random `out_ready`. Outputs match `decode_alu` in order, with no loss or duplication.
- Reset mid-operation:
  - With the buffer at count=2, pulse `RSTa` asynchronously between edges.
  - `out_valid` drops to 0 immediately, and no stale code appears afterwards.
  - `in_ready`=1 in the first cycle after release.
